// File: rtl/wdt_reset_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : wdt_reset_ctrl
// Description : Watchdog/software reset sequencer with retry counting and
//               sticky failsafe boot-source selection, on an 8-bit CSR bus.
// Revision    : 1.0 - initial release
// ============================================================================
module wdt_reset_ctrl #(
    parameter logic [4:0] BASE_ADDR = 5'h4,
    parameter logic [7:0] PULSE_LEN = 8'd16,
    parameter logic [7:0] HOLDOFF   = 8'd32,
    parameter logic [2:0] MAX_RETRY = 3'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       wdt_bite,
    input  logic       pwr_good,
    output logic       soc_reset_n,
    output logic       wdt_rst,
    output logic       failsafe_boot,
    output logic       irq
);

    localparam logic [1:0] c_ST_ASSERT  = 2'd0;
    localparam logic [1:0] c_ST_WAIT_PG = 2'd1;
    localparam logic [1:0] c_ST_HOLD    = 2'd2;
    localparam logic [1:0] c_ST_IDLE    = 2'd3;

    localparam logic [4:0] c_ADDR_CTRL  = BASE_ADDR;
    localparam logic [4:0] c_ADDR_STAT  = BASE_ADDR + 5'd1;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_cnt;
    logic [2:0] r_retry;
    logic [2:0] w_retry_inc;
    logic [1:0] r_cause;
    logic       r_failsafe;
    logic       r_irq;
    logic       r_bite_q;

    logic       w_wdt_ev;
    logic       w_sw_ev;
    logic       w_ctrl_wr;
    logic       w_stat_wr;
    logic       w_wdt_go;
    logic       w_sw_go;
    logic       w_fs_set;
    logic       w_unused;

    assign w_ctrl_wr = csr_we && (csr_a == c_ADDR_CTRL);
    assign w_stat_wr = csr_we && (csr_a == c_ADDR_STAT);
    assign w_wdt_ev  = wdt_bite && !r_bite_q;
    assign w_sw_ev   = w_ctrl_wr && csr_di[0];
    assign w_unused  = ^csr_di[7:2];

    assign w_retry_inc = (r_retry == 3'd7) ? 3'd7 : (r_retry + 3'd1);
    assign w_fs_set    = w_wdt_go && (w_retry_inc >= MAX_RETRY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_ASSERT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Events are only honoured in IDLE; a watchdog edge beats a software request.
    always_comb begin
        w_state_nxt = r_state;
        w_wdt_go    = 1'b0;
        w_sw_go     = 1'b0;
        soc_reset_n = 1'b0;
        wdt_rst     = 1'b0;
        case (r_state)
            c_ST_ASSERT: begin
                wdt_rst = 1'b1;
                if (r_cnt == 8'd0) begin
                    w_state_nxt = c_ST_WAIT_PG;
                end
            end
            c_ST_WAIT_PG: begin
                if (pwr_good) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                soc_reset_n = 1'b1;
                if (r_cnt == 8'd0) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_IDLE: begin
                soc_reset_n = 1'b1;
                if (w_wdt_ev) begin
                    w_state_nxt = c_ST_ASSERT;
                    w_wdt_go    = 1'b1;
                end else if (w_sw_ev) begin
                    w_state_nxt = c_ST_ASSERT;
                    w_sw_go     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_ASSERT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= PULSE_LEN;
            r_retry    <= 3'd0;
            r_cause    <= 2'b00;
            r_failsafe <= 1'b0;
            r_irq      <= 1'b0;
            r_bite_q   <= 1'b0;
        end else begin
            r_bite_q <= wdt_bite;
            r_irq    <= w_wdt_go;

            // Counter is reloaded on entry, otherwise it only moves on a tick.
            if ((w_state_nxt == c_ST_ASSERT) && (r_state != c_ST_ASSERT)) begin
                r_cnt <= PULSE_LEN;
            end else if ((w_state_nxt == c_ST_HOLD) && (r_state != c_ST_HOLD)) begin
                r_cnt <= HOLDOFF;
            end else if (ce && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end

            if (w_wdt_go) begin
                r_cause <= 2'b01;
            end else if (w_sw_go) begin
                r_cause <= 2'b10;
            end

            if (w_wdt_go) begin
                r_retry <= w_retry_inc;
            end else if (w_stat_wr) begin
                r_retry <= 3'd0;
            end

            if (w_fs_set) begin
                r_failsafe <= 1'b1;
            end else if (w_ctrl_wr && csr_di[1]) begin
                r_failsafe <= 1'b0;
            end
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (csr_a == c_ADDR_CTRL) begin
            csr_do = {6'b0, r_failsafe, 1'b0};
        end else if (csr_a == c_ADDR_STAT) begin
            csr_do = {1'b0, r_state, r_cause, r_retry};
        end
    end

    assign failsafe_boot = r_failsafe;
    assign irq           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wdt_reset_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_wdt_reset_ctrl
// Description : Scoreboard bench for wdt_reset_ctrl with directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wdt_reset_ctrl;

    localparam logic [4:0] c_CTRL = 5'h4;
    localparam logic [4:0] c_STAT = 5'h5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce;
    logic [4:0] csr_a = 5'h0;
    logic [7:0] csr_di = 8'h0;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic       wdt_bite = 1'b0;
    logic       pwr_good = 1'b1;
    logic       soc_reset_n;
    logic       wdt_rst;
    logic       failsafe_boot;
    logic       irq;

    logic [1:0] r_div;

    wdt_reset_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .csr_a         (csr_a),
        .csr_di        (csr_di),
        .csr_we        (csr_we),
        .csr_do        (csr_do),
        .wdt_bite      (wdt_bite),
        .pwr_good      (pwr_good),
        .soc_reset_n   (soc_reset_n),
        .wdt_rst       (wdt_rst),
        .failsafe_boot (failsafe_boot),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    // One tick every 4 clk, phase restarted by rst.
    always @(posedge clk) r_div <= rst ? 2'd0 : r_div + 2'd1;
    assign ce = (r_div == 2'd3);

    typedef struct {
        string name;
        int    lo;
        int    hi;
    } exp_t;

    exp_t q_rd[$];
    exp_t q_irq[$];
    exp_t q_rstn[$];

    int   total = 0;
    int   bad   = 0;

    logic mon_en  = 1'b0;
    logic rd_stb  = 1'b0;
    logic rd_pins = 1'b0;
    logic prev_n  = 1'b0;
    int   low_cnt = 0;
    int   irq_w   = 0;

    task automatic chk(input int which, input int act);
        exp_t  e;
        int    sz;
        string kind;
        kind = (which == 0) ? "rd" : (which == 1) ? "irq" : "rstn";
        sz   = (which == 0) ? q_rd.size() : (which == 1) ? q_irq.size() : q_rstn.size();
        total++;
        if (sz == 0) begin
            bad++;
            $display("FAIL unexpected_%s actual=%0d required=none", kind, act);
            return;
        end
        if (which == 0) e = q_rd.pop_front();
        else if (which == 1) e = q_irq.pop_front();
        else e = q_rstn.pop_front();
        if (act < e.lo || act > e.hi) begin
            bad++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d..%0d", e.name, act, act, e.lo, e.hi);
        end
    endtask

    // Monitor: reports reset-pin edges, irq pulse widths and CSR/pin probes.
    always @(negedge clk) begin
        if (mon_en) begin
            if (soc_reset_n !== prev_n) begin
                if (soc_reset_n === 1'b0) chk(2, int'({wdt_rst, irq}));
                else chk(2, low_cnt);
            end
            if (irq === 1'b1) begin
                irq_w++;
            end else if (irq_w != 0) begin
                chk(1, irq_w);
                irq_w = 0;
            end
            if (rd_stb) begin
                chk(0, rd_pins ? int'({4'b0, irq, failsafe_boot, wdt_rst, soc_reset_n}) : int'(csr_do));
            end
        end
        if (rst) low_cnt = 0;
        else if (soc_reset_n === 1'b0) low_cnt++;
        else low_cnt = 0;
        prev_n = soc_reset_n;
    end

    task automatic push(input int which, input string n, input int lo, input int hi);
        exp_t e;
        e.name = n;
        e.lo   = lo;
        e.hi   = hi;
        if (which == 0) q_rd.push_back(e);
        else if (which == 1) q_irq.push_back(e);
        else q_rstn.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic pins, input int v, input string n);
        push(0, n, v, v);
        csr_a   = a;
        rd_pins = pins;
        rd_stb  = 1'b1;
        tick(1);
        rd_stb  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        tick(1);
        csr_we = 1'b0;
        csr_di = 8'h00;
    endtask

    task automatic wait_lvl(input logic lvl, input int budget, input string n);
        int k;
        k = 0;
        while (soc_reset_n !== lvl && k < budget) begin
            tick(1);
            k++;
        end
        if (k >= budget) begin
            total++;
            bad++;
            $display("FAIL %s actual=timeout required=soc_reset_n=%0d", n, lvl);
        end
    endtask

    // trig: 0 = watchdog bite, 1 = software request, 2 = both in the same clk
    task automatic run_seq(input int trig, input int st_a, input int st_h,
                           input int st_i, input int ctrl_a, input string n);
        push(2, {n, "_fall"}, (trig == 1) ? 2 : 3, (trig == 1) ? 2 : 3);
        if (trig != 1) push(1, {n, "_irq_width"}, 1, 1);
        push(2, {n, "_low_len"}, 63, 66);
        if (trig != 1) wdt_bite = 1'b1;
        if (trig != 0) wr(c_CTRL, 8'h01);
        tick(3);
        rd(c_STAT, 1'b0, st_a, {n, "_stat_assert"});
        rd(c_CTRL, 1'b0, ctrl_a, {n, "_ctrl_assert"});
        wait_lvl(1'b1, 100, {n, "_wait_release"});
        rd(c_STAT, 1'b0, st_h, {n, "_stat_hold"});
        wr(c_CTRL, 8'h01);
        rd(c_STAT, 1'b0, st_h, {n, "_stat_hold_swreq"});
        tick(140);
        rd(c_STAT, 1'b0, st_i, {n, "_stat_idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        push(2, "por_low_len", 66, 66);
        rst = 1'b0;
        rd(c_STAT, 1'b0, 8'h00, "por_stat");
        rd(c_CTRL, 1'b0, 8'h00, "por_ctrl");
        rd(c_STAT, 1'b1, 8'h02, "por_pins");
        wait_lvl(1'b1, 100, "por_release");
        rd(c_STAT, 1'b0, 8'h40, "por_stat_hold");
        tick(140);
        rd(c_STAT, 1'b0, 8'h60, "por_stat_idle");
        rd(c_STAT, 1'b1, 8'h01, "por_pins_idle");

        // First bite is held high through the whole sequence: no second reset.
        run_seq(0, 8'h09, 8'h49, 8'h69, 8'h00, "bite1");
        wdt_bite = 1'b0;
        tick(2);
        run_seq(0, 8'h0A, 8'h4A, 8'h6A, 8'h00, "bite2");
        wdt_bite = 1'b0;
        tick(2);
        run_seq(0, 8'h0B, 8'h4B, 8'h6B, 8'h02, "bite3");
        wdt_bite = 1'b0;
        tick(2);
        rd(c_CTRL, 1'b0, 8'h02, "fs_ctrl_idle");
        rd(c_STAT, 1'b1, 8'h05, "fs_pins_idle");
        wr(c_CTRL, 8'h02);
        rd(c_CTRL, 1'b0, 8'h00, "fs_cleared");

        run_seq(1, 8'h13, 8'h53, 8'h73, 8'h00, "sw");
        wr(c_STAT, 8'hFF);
        rd(c_STAT, 1'b0, 8'h70, "retry_cleared");

        // Rails not good: reset is held in WAIT_PG until pwr_good rises.
        pwr_good = 1'b0;
        push(2, "pg_fall", 3, 3);
        push(1, "pg_irq_width", 1, 1);
        push(2, "pg_low_len", 95, 115);
        wdt_bite = 1'b1;
        wait_lvl(1'b0, 10, "pg_wait_assert");
        tick(100);
        rd(c_STAT, 1'b0, 8'h29, "pg_stat_wait");
        rd(c_STAT, 1'b1, 8'h00, "pg_pins_wait");
        pwr_good = 1'b1;
        tick(1);
        rd(c_STAT, 1'b0, 8'h49, "pg_stat_hold");
        tick(140);
        rd(c_STAT, 1'b0, 8'h69, "pg_stat_idle");
        wdt_bite = 1'b0;
        tick(2);

        // Bite and software request together, then rst during HOLD.
        push(2, "both_fall", 3, 3);
        push(1, "both_irq_width", 1, 1);
        push(2, "both_low_len", 63, 66);
        wdt_bite = 1'b1;
        wr(c_CTRL, 8'h01);
        tick(2);
        rd(c_STAT, 1'b0, 8'h0A, "both_stat_assert");
        wait_lvl(1'b1, 100, "both_release");
        rd(c_STAT, 1'b0, 8'h4A, "both_stat_hold");
        push(2, "rst_fall", 2, 2);
        push(2, "rst_low_len", 66, 66);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rd(c_STAT, 1'b0, 8'h00, "rst_stat");
        rd(c_STAT, 1'b1, 8'h02, "rst_pins");
        wait_lvl(1'b1, 100, "rst_release");
        rd(c_STAT, 1'b0, 8'h40, "rst_stat_hold");
        tick(140);
        rd(c_STAT, 1'b0, 8'h60, "rst_stat_idle");
        wdt_bite = 1'b0;
        tick(5);

        while (q_rd.size() > 0) begin
            e = q_rd.pop_front();
            total++;
            bad++;
            $display("FAIL %s actual=none required=%0d", e.name, e.lo);
        end
        while (q_irq.size() > 0) begin
            e = q_irq.pop_front();
            total++;
            bad++;
            $display("FAIL %s actual=none required=%0d", e.name, e.lo);
        end
        while (q_rstn.size() > 0) begin
            e = q_rstn.pop_front();
            total++;
            bad++;
            $display("FAIL %s actual=none required=%0d..%0d", e.name, e.lo, e.hi);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wdt_reset_ctrl.md
Name: wdt_reset_ctrl

Overview:
Reset sequencer behind the board watchdog. It turns a watchdog bite, or a software request, into a timed SoC reset pulse. It re-arms the watchdog and counts consecutive watchdog-caused resets. After too many, it latches failsafe boot selection. It sits on the shared 8-bit CSR bus next to the watchdog and drives the SoC reset pin and the boot-source strap.

Parameters:
BASE_ADDR, 5'h4, CSR window base (two registers)
PULSE_LEN, 8'd16, reset-assert length in ce ticks
HOLDOFF, 8'd32, ce ticks after release during which bites are ignored
MAX_RETRY, 3'd3, watchdog resets before failsafe_boot latches

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ce  in  1  timebase tick, one clk wide
csr_a  in  5  CSR address
csr_di  in  8  CSR write data
csr_we  in  1  CSR write strobe
csr_do  out  8  CSR read data, combinational, 0 outside the window
wdt_bite  in  1  OR of watchdog outputs, level, stays high until re-armed
pwr_good  in  1  SoC rails good, already synchronised
soc_reset_n  out  1  SoC reset, active low
wdt_rst  out  1  watchdog re-arm, high while in ASSERT
failsafe_boot  out  1  boot-source select, sticky
irq  out  1  one-clk pulse on entering ASSERT due to watchdog

Behaviour:
- States: ASSERT, WAIT_PG, HOLD, IDLE. Encoding for status: ASSERT=0, WAIT_PG=1, HOLD=2, IDLE=3.
- rst values: state=ASSERT, tick counter=PULSE_LEN, retry_cnt=0, cause=2'b00 (POR), failsafe_boot=0, irq=0, bite_q=0.
  - Outputs during and after rst follow the state: soc_reset_n=0, wdt_rst=1.
- soc_reset_n=0 in ASSERT and WAIT_PG, 1 otherwise. wdt_rst=(state==ASSERT).
- Tick counter:
  - Loaded on every state entry: PULSE_LEN for ASSERT, HOLDOFF for HOLD.
  - Decrements on ce while non-zero.
  - Leaving ASSERT or HOLD happens on the clk after the counter reads 0.
  - A value of 0 therefore lasts exactly one clk.
- ASSERT -> WAIT_PG when the counter is 0.
- WAIT_PG -> HOLD on the first clk with pwr_good=1. No timeout; it waits indefinitely.
- HOLD -> IDLE when the counter is 0.
- IDLE -> ASSERT on a wdt event or a sw event.
  - wdt event = wdt_bite & !bite_q, where bite_q is wdt_bite registered every clk.
  - sw event = CSR write to BASE_ADDR+0 with csr_di[0]=1.
  - A wdt event sets cause=2'b01. A sw event sets cause=2'b10.
  - Simultaneous wdt and sw events: wdt wins (cause=01, irq=1).
- wdt events and sw requests outside IDLE are dropped, not queued.
  - Exception: wdt_bite still high when entering IDLE with bite_q=1 does not retrigger. Only a fresh rising edge does.
- retry_cnt:
  - +1 on each wdt-caused ASSERT entry, saturating at 7.
  - When the increment makes retry_cnt >= MAX_RETRY, failsafe_boot <= 1 in the same clk.
  - sw-caused resets do not change retry_cnt.
- failsafe_boot is cleared only by rst or by a CSR write to BASE_ADDR+0 with csr_di[1]=1.
  - A clear in the same clk as a setting increment loses: the set wins.
- CSR map:
  - BASE_ADDR+0 CTRL: read {6'b0, failsafe_boot, 1'b0}. Bit0 is a write-only request.
  - BASE_ADDR+1 STAT: read {1'b0, state[1:0], cause[1:0], retry_cnt[2:0]}. Any write clears retry_cnt to 0; cause and state are unaffected.
- Synchronous rst mid-sequence restarts at ASSERT with a full PULSE_LEN count.

Test Plan:
- POR, PULSE_LEN=16, ce every 4 clk, pwr_good=1 -> soc_reset_n low for ~64 clk; then HOLD for 32 ticks; then IDLE; STAT reads 8'h60.
- Raise wdt_bite in IDLE -> irq high exactly 1 clk; soc_reset_n=0 next clk; wdt_rst=1; STAT cause=01, retry_cnt=1.
- Three bites, each after returning to IDLE, MAX_RETRY=3 -> failsafe_boot rises on the third ASSERT entry; CTRL reads 8'h02; write CTRL 8'h02 -> CTRL reads 8'h00.
- Write CTRL 8'h01 in IDLE -> reset sequence with cause=10 and irq=0; retry_cnt unchanged. Repeat the write during HOLD -> ignored, state stays HOLD.
- Hold pwr_good=0 after ASSERT completes -> state stays WAIT_PG (STAT[6:5]=1) and soc_reset_n stays 0. Raise pwr_good -> HOLD next clk.
- Bite and sw write in the same clk -> cause=01, irq pulses. Bite held high through the whole sequence -> no second reset. Assert rst in HOLD -> back to ASSERT, counter 16.
